sync_input_debouncer: RTL and testbench
=======================================

// Module: sync_input_debouncer
// PURPOSE
//   Consumes a single-bit input from a double-flop synchronizer (or any slow external pin)
//   and removes glitches/bounce. Input must hold a new value for STABLE_CYCLES consecutive
//   enabled cycles before the debounced level follows it. Emits one-cycle rise/fall
//   strobes on each accepted change. Sits between chip-input synchronization and control logic.
// PARAMETERS
//   STABLE_CYCLES  16  consecutive enabled cycles a new value must persist; legal >= 1, 0 = elaboration error
//   RESET_LEVEL    0   value of level (and internal sync flops) during reset
// PORTS
//   clk     input   1  clock
//   rst     input   1  reset, asynchronous, active-low
//   enable  input   1  qualification tick; when low, all state holds
//   in      input   1  raw/synchronized input sample
//   level   output  1  debounced level
//   rise    output  1  one-cycle strobe, level went 0->1
//   fall    output  1  one-cycle strobe, level went 1->0
//   busy    output  1  high while a candidate change is being qualified
// BEHAVIOUR
//   - Reset (rst=0, async): level=RESET_LEVEL, rise=fall=busy=0, counter=0, state IDLE.
//   - All outputs registered; counter width $clog2(STABLE_CYCLES+1).
//   - sample = in (or internal sync output, see CONFIGURATION).
//   - FSM, evaluated only on cycles with enable=1:
//       IDLE:    sample==level -> stay, counter=0.
//                sample!=level -> if STABLE_CYCLES==1 accept now; else counter=1, -> QUALIFY.
//       QUALIFY: sample==level -> abort: counter=0, -> IDLE, no strobe.
//                sample!=level, counter==STABLE_CYCLES-1 -> accept.
//                sample!=level otherwise -> counter+1, stay.
//       accept:  level<=~level, rise or fall <=1 for that cycle, counter=0, -> IDLE.
//   - Latency: with enable tied high, level changes on the edge closing the STABLE_CYCLES-th
//     consecutive differing sample; new level and strobe visible the following cycle together.
//   - busy=1 exactly while state==QUALIFY (registered, same cycle as counter>=1).
//   - rise/fall: never both high; each high for exactly one clk cycle regardless of enable.
//   - enable=0: counter, state, level hold; rise/fall forced 0; samples ignored (no abort).
//   - Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.
//   - Reset asserted mid-QUALIFY: candidate discarded; after release no strobe unless
//     input again persists STABLE_CYCLES cycles against RESET_LEVEL.
//   - Input toggling every cycle: level never changes, busy alternates, no strobes.
// CONFIGURATION
//   DEBOUNCER_INPUT_SYNC_EN
//   - Defined: in passes through two internal flops (reset to RESET_LEVEL, advance every
//     cycle independent of enable) before becoming sample; adds exactly 2 cycles latency.
//     Use when in is driven directly from an asynchronous pin.
//   - Undefined: sample = in directly; in must already be synchronous to clk.
// TESTING (default macro undefined unless noted)
//   - Reset: rst=0 with in toggling, RESET_LEVEL=1 -> level=1, rise=fall=busy=0 throughout.
//   - STABLE_CYCLES=4, enable=1, in 0->1 held -> busy high 3 cycles, level=1 and rise=1 one
//     cycle 4 cycles after first high sample; rise low next cycle.
//   - STABLE_CYCLES=4, in high 3 cycles then low -> busy drops, level stays 0, no rise.
//   - STABLE_CYCLES=4, enable high every 2nd cycle, in held high -> level rises after 4
//     enabled samples (~8 cycles); counter holds on enable=0 cycles.
//   - STABLE_CYCLES=4, rst pulsed low at counter=2 -> busy=0, level=0 immediately; in held
//     high after release -> rise after 4 more cycles.
//   - DEBOUNCER_INPUT_SYNC_EN defined, STABLE_CYCLES=1 -> level follows in 3 cycles late; fall
//     strobe on 1->0.

Source files
------------

// File: rtl/sync_input_debouncer.sv
// sync_input_debouncer
//   Glitch/bounce filter for a single-bit input. A new input value must be
//   seen on STABLE_CYCLES consecutive enabled cycles before the debounced
//   level follows it; each accepted change emits a one-cycle rise/fall strobe.
//   Optional feature macro: DEBOUNCER_INPUT_SYNC_EN
//     defined   -> in_i passes through a two-flop synchronizer (+2 cycles)
//     undefined -> in_i is used directly and must already be synchronous
module sync_input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  // Width holds 0..STABLE_CYCLES; clamp keeps declarations legal when the
  // parameter is illegal so that the elaboration error below is what reports.
  localparam int unsigned CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("sync_input_debouncer: STABLE_CYCLES must be >= 1");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             sample;

`ifdef DEBOUNCER_INPUT_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer; runs every cycle so enable never stalls it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = in_i;
`endif

  // Next-state logic: qualify a candidate change, abort on any agreeing sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    accept  = 1'b0;
    if (enable_i) begin
      unique case (state_q)
        IDLE: begin
          if (sample != level_q) begin
            if (STABLE_CYCLES == 1) begin
              accept = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = QUALIFY;
            end
          end else begin
            cnt_d = '0;
          end
        end
        QUALIFY: begin
          if (sample == level_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            accept = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
      if (accept) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
        fall_d  = level_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  assign busy_d = (state_d == QUALIFY);

  // State and registered outputs; strobes clear on the following edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_sync_input_debouncer.sv
// Testbench for sync_input_debouncer: three instances with different
// STABLE_CYCLES / RESET_LEVEL share one stimulus and are compared each cycle
// against a history-based model; directed sections pin literal timings.
module tb_sync_input_debouncer;

`ifdef DEBOUNCER_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
  localparam bit SYNC     = 1'b1;
`else
  localparam int SYNC_LAT = 0;
  localparam bit SYNC     = 1'b0;
`endif

  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic enable;
  logic in_s;
  logic cmp_on = 1'b0;

  logic level_w [N];
  logic rise_w  [N];
  logic fall_w  [N];
  logic busy_w  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int s_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 5;
  endfunction

  function automatic logic rl_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    sync_input_debouncer #(
      .STABLE_CYCLES((gi == 0) ? 4 : (gi == 1) ? 1 : 5),
      .RESET_LEVEL  ((gi == 0) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .enable_i(enable),
      .in_i    (in_s),
      .level_o (level_w[gi]),
      .rise_o  (rise_w[gi]),
      .fall_o  (fall_w[gi]),
      .busy_o  (busy_w[gi])
    );
  end

  // Model: keeps the enabled samples seen since the last level change; the
  // level flips once the newest s samples all disagree with it.
  typedef struct packed {
    logic [63:0] hist;
    logic [6:0]  hlen;
    logic        level;
    logic        rise;
    logic        fall;
    logic        busy;
    logic        s1;
    logic        s2;
  } mstate_t;

  mstate_t m_q [N];

  function automatic mstate_t model_reset(input logic rl);
    mstate_t r;
    r       = '0;
    r.level = rl;
    r.s1    = rl;
    r.s2    = rl;
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t cur, input logic en,
                                         input logic d, input int s);
    mstate_t nx;
    logic    smp;
    int      n;
    nx      = cur;
    smp     = SYNC ? cur.s2 : d;
    nx.s1   = d;
    nx.s2   = cur.s1;
    nx.rise = 1'b0;
    nx.fall = 1'b0;
    if (en) begin
      nx.hist = {cur.hist[62:0], smp};
      nx.hlen = (cur.hlen < 7'd63) ? cur.hlen + 7'd1 : 7'd63;
      n = 0;
      for (int k = 0; k < 64; k++) begin
        if (k >= int'(nx.hlen)) break;
        if (nx.hist[k] == cur.level) break;
        n++;
      end
      if (n >= s) begin
        nx.level = ~cur.level;
        nx.rise  = ~cur.level;
        nx.fall  = cur.level;
        nx.hist  = '0;
        nx.hlen  = '0;
        nx.busy  = 1'b0;
      end else begin
        nx.busy = (n > 0);
      end
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) m_q[i] <= model_reset(rl_of(i));
      else        m_q[i] <= model_step(m_q[i], enable, in_s, s_of(i));
    end
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < N; i++) begin
        check("level", i, int'(level_w[i]), int'(m_q[i].level));
        check("rise",  i, int'(rise_w[i]),  int'(m_q[i].rise));
        check("fall",  i, int'(fall_w[i]),  int'(m_q[i].fall));
        check("busy",  i, int'(busy_w[i]),  int'(m_q[i].busy));
        check("rise_fall_excl", i, int'(rise_w[i] & fall_w[i]), 0);
      end
    end
  end

  task automatic step(input logic en, input logic d);
    enable = en;
    in_s   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    enable = 1'b1;
    in_s   = 1'b0;
    #1 rst_n = 1'b0;
    #1 cmp_on = 1'b1;

    // Reset held while the input toggles.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, k[0]);
      check("rst_level", 0, int'(level_w[0]), 0);
      check("rst_level", 1, int'(level_w[1]), 1);
      check("rst_level", 2, int'(level_w[2]), 1);
      check("rst_busy",  0, int'(busy_w[0]), 0);
      check("rst_rise",  2, int'(rise_w[2]), 0);
      check("rst_fall",  1, int'(fall_w[1]), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6 + SYNC_LAT; k++) step(1'b1, 1'b0);

    // Abort: three high samples then low; no change on instance 0.
    for (int j = 1; j <= 6 + SYNC_LAT; j++) begin
      step(1'b1, (j <= 3));
      if (j == 3 + SYNC_LAT) check("abort_busy_hi", 0, int'(busy_w[0]), 1);
      if (j == 4 + SYNC_LAT) check("abort_busy_lo", 0, int'(busy_w[0]), 0);
      check("abort_level", 0, int'(level_w[0]), 0);
      check("abort_rise",  0, int'(rise_w[0]), 0);
    end

    // Rise: held high; busy for 3 cycles, then level and strobe together.
    for (int j = 1; j <= 6 + SYNC_LAT; j++) begin
      int e;
      step(1'b1, 1'b1);
      e = j - SYNC_LAT;
      check("rise_busy",  0, int'(busy_w[0]),  int'(e >= 1 && e <= 3));
      check("rise_level", 0, int'(level_w[0]), int'(e >= 4));
      check("rise_rise",  0, int'(rise_w[0]),  int'(e == 4));
      check("model_rise", 0, int'(m_q[0].rise), int'(e == 4));
    end

    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    check("fall_back_level", 0, int'(level_w[0]), 0);

    // Reset in the middle of qualification.
    for (int j = 1; j <= 2 + SYNC_LAT; j++) step(1'b1, 1'b1);
    check("midq_busy_before", 0, int'(busy_w[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midq_busy_rst",  0, int'(busy_w[0]), 0);
    check("midq_level_rst", 0, int'(level_w[0]), 0);
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    for (int j = 1; j <= 6 + SYNC_LAT; j++) begin
      step(1'b1, 1'b1);
      check("midq_level", 0, int'(level_w[0]), int'(j >= 4 + SYNC_LAT));
      check("midq_rise",  0, int'(rise_w[0]),  int'(j == 4 + SYNC_LAT));
    end

    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);

    // Enable on every second cycle: only enabled samples count.
    for (int n = 1; n <= 9 + SYNC_LAT; n++) begin
      step(n[0], 1'b1);
      check("en2_level", 0, int'(level_w[0]), int'(n >= 7 + SYNC_LAT));
      check("en2_rise",  0, int'(rise_w[0]),  int'(n == 7 + SYNC_LAT));
      check("en2_busy",  0, int'(busy_w[0]),  int'(n >= 1 + SYNC_LAT && n < 7 + SYNC_LAT));
    end

    // Single-cycle qualification on instance 1: fall strobe on 1->0.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
    for (int j = 1; j <= 4 + SYNC_LAT; j++) begin
      step(1'b1, 1'b0);
      check("s1_fall",  1, int'(fall_w[1]),  int'(j == 1 + SYNC_LAT));
      check("s1_level", 1, int'(level_w[1]), int'(j < 1 + SYNC_LAT));
    end

    // Input toggling every cycle: instance 0 level must not move.
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1);
    for (int j = 0; j < 20; j++) begin
      step(1'b1, j[0]);
      check("tog_level", 0, int'(level_w[0]), 1);
      check("tog_fall",  0, int'(fall_w[0]), 0);
    end

    // Randomized runs with occasional reset pulses.
    for (int r = 0; r < 600; r++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 199) == 0) begin
          rst_n = 1'b0;
          step(1'($urandom_range(0, 1)), v);
          rst_n = 1'b1;
        end else begin
          step(($urandom_range(0, 3) != 0), v);
        end
      end
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
